// File: rtl/pong_game_ctrl.sv
// Pong game-state controller: turns level-type hit/win flags from the graphics block
// into single scoring events, keeps both scores, holds the ball between rallies and fires sound pulses.
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 5,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int TICK_Y       = 481
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       btn_start,
  input  logic       hit,
  input  logic       l_win,
  input  logic       r_win,
  output logic       gra_still,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic       winner_l,
  output logic       snd_hit,
  output logic       snd_point,
  output logic [2:0] state_o
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_POINT = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam logic [3:0] WIN_V     = WIN_SCORE[3:0];
  localparam logic [7:0] SERVE_CNT = SERVE_FRAMES[7:0];
  localparam logic [7:0] POINT_CNT = POINT_FRAMES[7:0];
  localparam logic [9:0] TICK_Y_V  = TICK_Y[9:0];

  logic [2:0] state;
  logic [7:0] cnt;
  logic       btn_d1;
  logic       hit_d1;
  logic       armed;

  logic tick;
  logic start_evt;
  logic hit_evt;
  logic l_reached;
  logic r_reached;

  assign tick      = (pix_y == TICK_Y_V) && (pix_x == 10'd0);
  // armed stays low for the first cycle after reset so a button held through
  // reset is absorbed into btn_d1 instead of looking like a fresh press.
  assign start_evt = btn_start & ~btn_d1 & armed;
  assign hit_evt   = hit & ~hit_d1;
  assign l_reached = (score_l == WIN_V);
  assign r_reached = (score_r == WIN_V);
  assign state_o   = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_d1 <= 1'b0;
      hit_d1 <= 1'b0;
      armed  <= 1'b0;
    end else begin
      btn_d1 <= btn_start;
      hit_d1 <= hit;
      armed  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= 8'd0;
      gra_still <= 1'b1;
      score_l   <= 4'd0;
      score_r   <= 4'd0;
      game_over <= 1'b0;
      winner_l  <= 1'b0;
      snd_hit   <= 1'b0;
      snd_point <= 1'b0;
    end else begin
      snd_hit   <= 1'b0;
      snd_point <= 1'b0;
      case (state)
        ST_IDLE: begin
          gra_still <= 1'b1;
          if (start_evt) begin
            state <= ST_SERVE;
            cnt   <= SERVE_CNT;
          end
        end

        ST_SERVE: begin
          gra_still <= 1'b1;
          if (tick) begin
            if (cnt <= 8'd1) begin
              state     <= ST_PLAY;
              cnt       <= 8'd0;
              gra_still <= 1'b0;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
        end

        ST_PLAY: begin
          gra_still <= 1'b0;
          snd_hit   <= hit_evt;
          // Leaving PLAY on the first win sample is what limits a long win
          // flag to a single point.
          if (l_win || r_win) begin
            state     <= ST_POINT;
            cnt       <= POINT_CNT;
            gra_still <= 1'b1;
            if (l_win && !r_win) begin
              snd_point <= 1'b1;
              if (score_l < WIN_V) score_l <= score_l + 4'd1;
            end else if (r_win && !l_win) begin
              snd_point <= 1'b1;
              if (score_r < WIN_V) score_r <= score_r + 4'd1;
            end
          end
        end

        ST_POINT: begin
          gra_still <= 1'b1;
          if (tick) begin
            if (cnt <= 8'd1) begin
              if (l_reached || r_reached) begin
                state     <= ST_OVER;
                cnt       <= 8'd0;
                game_over <= 1'b1;
                winner_l  <= l_reached;
              end else begin
                state <= ST_SERVE;
                cnt   <= SERVE_CNT;
              end
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
        end

        ST_OVER: begin
          gra_still <= 1'b1;
          if (start_evt) begin
            state     <= ST_SERVE;
            cnt       <= SERVE_CNT;
            score_l   <= 4'd0;
            score_r   <= 4'd0;
            game_over <= 1'b0;
          end
        end

        default: begin
          state     <= ST_IDLE;
          cnt       <= 8'd0;
          gra_still <= 1'b1;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: scenario tasks drive pixel ticks, buttons and win/hit
// flags; expected scores are queued on each win and popped when snd_point fires.
module tb_pong_game_ctrl;

  localparam int TICK_Y = 481;
  localparam logic [3:0] WIN = 4'd5;

  logic       clk;
  logic       reset;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       btn_start;
  logic       hit;
  logic       l_win;
  logic       r_win;
  logic       gra_still;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       game_over;
  logic       winner_l;
  logic       snd_hit;
  logic       snd_point;
  logic [2:0] state_o;

  int n_cmp;
  int n_err;
  logic [7:0] exp_q[$];
  logic [3:0] exp_l;
  logic [3:0] exp_r;

  int hit_cycles;
  int hit_rises;
  int point_cycles;
  logic snd_hit_q;

  pong_game_ctrl #(
    .WIN_SCORE(5), .SERVE_FRAMES(60), .POINT_FRAMES(90), .TICK_Y(TICK_Y)
  ) dut (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
    .btn_start(btn_start), .hit(hit), .l_win(l_win), .r_win(r_win),
    .gra_still(gra_still), .score_l(score_l), .score_r(score_r),
    .game_over(game_over), .winner_l(winner_l), .snd_hit(snd_hit),
    .snd_point(snd_point), .state_o(state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse counters
  initial begin
    hit_cycles = 0;
    hit_rises = 0;
    point_cycles = 0;
    snd_hit_q = 1'b0;
  end
  always @(negedge clk) begin
    if (snd_hit === 1'b1) hit_cycles++;
    if (snd_hit === 1'b1 && snd_hit_q !== 1'b1) hit_rises++;
    snd_hit_q = snd_hit;
    if (snd_point === 1'b1) point_cycles++;
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_pix();
    pix_y = 10'($urandom_range(0, 480));
    pix_x = 10'($urandom_range(0, 799));
  endtask

  // One tick cycle followed by a near-miss cycle (right row, wrong column).
  task automatic tick_n(input int n);
    repeat (n) begin
      pix_y = 10'(TICK_Y);
      pix_x = 10'd0;
      step(1);
      pix_y = 10'(TICK_Y);
      pix_x = 10'($urandom_range(1, 799));
      step(1);
    end
    idle_pix();
  endtask

  task automatic play_point(input logic lw, input logic rw);
    logic [7:0] e;
    l_win = lw;
    r_win = rw;
    if (lw && !rw) begin
      if (exp_l < WIN) exp_l = exp_l + 4'd1;
      exp_q.push_back({exp_l, exp_r});
    end else if (rw && !lw) begin
      if (exp_r < WIN) exp_r = exp_r + 4'd1;
      exp_q.push_back({exp_l, exp_r});
    end
    step(1);
    n_cmp++;
    if (lw ^ rw) begin
      if (snd_point !== 1'b1 || exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_point: snd_point=%b queued=%0d, required pulse with queued score", snd_point, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        if ({score_l, score_r} !== e) begin
          n_err++;
          $display("FAIL sb_score: got %0d:%0d required %0d:%0d", score_l, score_r, e[7:4], e[3:0]);
        end
      end
    end else if (snd_point !== 1'b0 || {score_l, score_r} !== {exp_l, exp_r}) begin
      n_err++;
      $display("FAIL void_rally: snd_point=%b score %0d:%0d required 0 and %0d:%0d", snd_point, score_l, score_r, exp_l, exp_r);
    end
    n_cmp++;
    if (state_o !== 3'd3 || gra_still !== 1'b1) begin
      n_err++;
      $display("FAIL enter_point: state=%0d gra_still=%b required 3 and 1", state_o, gra_still);
    end
    l_win = 1'b0;
    r_win = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b0;
    step(3);
    reset = 1'b1;
    step(1);
    n_cmp++;
    if (state_o !== 3'd0 || gra_still !== 1'b1 || score_l !== 4'd0 || score_r !== 4'd0 ||
        game_over !== 1'b0 || winner_l !== 1'b0 || snd_hit !== 1'b0 || snd_point !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: state=%0d still=%b score=%0d:%0d over=%b win_l=%b snd=%b%b required 0,1,0:0,0,0,00",
               state_o, gra_still, score_l, score_r, game_over, winner_l, snd_hit, snd_point);
    end
  endtask

  task automatic test_serve();
    step(2);
    btn_start = 1'b1;
    step(1);
    n_cmp++;
    if (state_o !== 3'd1 || gra_still !== 1'b1) begin
      n_err++;
      $display("FAIL serve_entry: state=%0d still=%b required 1 and 1", state_o, gra_still);
    end
    tick_n(59);
    n_cmp++;
    if (state_o !== 3'd1 || gra_still !== 1'b1) begin
      n_err++;
      $display("FAIL serve_59: state=%0d still=%b required 1 and 1", state_o, gra_still);
    end
    tick_n(1);
    n_cmp++;
    if (state_o !== 3'd2 || gra_still !== 1'b0) begin
      n_err++;
      $display("FAIL serve_60: state=%0d still=%b required 2 and 0", state_o, gra_still);
    end
    btn_start = 1'b0;
    step(1);
  endtask

  task automatic test_point_once();
    int p0;
    p0 = point_cycles;
    play_point(1'b1, 1'b0);
    l_win = 1'b1;
    step(499);
    l_win = 1'b0;
    step(1);
    n_cmp++;
    if (score_l !== 4'd1 || score_r !== 4'd0 || point_cycles - p0 !== 1 || snd_point !== 1'b0) begin
      n_err++;
      $display("FAIL hold_l_win: score=%0d:%0d pulses=%0d snd_point=%b required 1:0, 1 pulse, 0",
               score_l, score_r, point_cycles - p0, snd_point);
    end
    tick_n(89);
    n_cmp++;
    if (state_o !== 3'd3) begin
      n_err++;
      $display("FAIL point_89: state=%0d required 3", state_o);
    end
    tick_n(1);
    n_cmp++;
    if (state_o !== 3'd1 || game_over !== 1'b0) begin
      n_err++;
      $display("FAIL point_90: state=%0d over=%b required 1 and 0", state_o, game_over);
    end
    tick_n(60);
  endtask

  task automatic test_hit();
    int r0, c0;
    r0 = hit_rises;
    c0 = hit_cycles;
    hit = 1'b1;
    step(300);
    hit = 1'b0;
    step(5);
    hit = 1'b1;
    step(10);
    hit = 1'b0;
    step(3);
    n_cmp++;
    if (hit_rises - r0 !== 2 || hit_cycles - c0 !== 2 || state_o !== 3'd2) begin
      n_err++;
      $display("FAIL hit_pulses: rises=%0d cycles=%0d state=%0d required 2, 2, 2",
               hit_rises - r0, hit_cycles - c0, state_o);
    end
  endtask

  task automatic test_start_ignored();
    btn_start = 1'b1;
    step(3);
    btn_start = 1'b0;
    step(1);
    n_cmp++;
    if (state_o !== 3'd2 || gra_still !== 1'b0) begin
      n_err++;
      $display("FAIL start_in_play: state=%0d still=%b required 2 and 0", state_o, gra_still);
    end
  endtask

  task automatic test_void();
    play_point(1'b1, 1'b1);
    tick_n(90);
    n_cmp++;
    if (state_o !== 3'd1 || score_l !== 4'd1 || score_r !== 4'd0) begin
      n_err++;
      $display("FAIL void_resume: state=%0d score=%0d:%0d required 1 and 1:0", state_o, score_l, score_r);
    end
    tick_n(60);
  endtask

  task automatic test_game_over();
    for (int k = 1; k <= 5; k++) begin
      play_point(1'b0, 1'b1);
      if (k < 5) begin
        tick_n(90);
        tick_n(60);
      end
    end
    tick_n(89);
    n_cmp++;
    if (state_o !== 3'd3 || game_over !== 1'b0) begin
      n_err++;
      $display("FAIL over_89: state=%0d over=%b required 3 and 0", state_o, game_over);
    end
    tick_n(1);
    n_cmp++;
    if (state_o !== 3'd4 || game_over !== 1'b1 || winner_l !== 1'b0 || score_r !== 4'd5 ||
        score_l !== 4'd1 || gra_still !== 1'b1) begin
      n_err++;
      $display("FAIL game_over: state=%0d over=%b win_l=%b score=%0d:%0d still=%b required 4,1,0,1:5,1",
               state_o, game_over, winner_l, score_l, score_r, gra_still);
    end
    tick_n(5);
    btn_start = 1'b1;
    step(1);
    exp_l = 4'd0;
    exp_r = 4'd0;
    n_cmp++;
    if (state_o !== 3'd1 || score_l !== 4'd0 || score_r !== 4'd0 || game_over !== 1'b0) begin
      n_err++;
      $display("FAIL restart: state=%0d score=%0d:%0d over=%b required 1, 0:0, 0",
               state_o, score_l, score_r, game_over);
    end
    btn_start = 1'b0;
    tick_n(60);
  endtask

  task automatic test_reset_mid_point();
    logic [4:0] pat;
    pat = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      play_point(pat[i], ~pat[i]);
      if (i < 4) begin
        tick_n(90);
        tick_n(60);
      end
    end
    tick_n(10);
    btn_start = 1'b1;
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    exp_l = 4'd0;
    exp_r = 4'd0;
    n_cmp++;
    if (state_o !== 3'd0 || score_l !== 4'd0 || score_r !== 4'd0 || gra_still !== 1'b1 || snd_point !== 1'b0) begin
      n_err++;
      $display("FAIL reset_in_point: state=%0d score=%0d:%0d still=%b snd_point=%b required 0, 0:0, 1, 0",
               state_o, score_l, score_r, gra_still, snd_point);
    end
    step(5);
    n_cmp++;
    if (state_o !== 3'd0) begin
      n_err++;
      $display("FAIL held_btn_after_reset: state=%0d required 0", state_o);
    end
    btn_start = 1'b0;
    step(2);
    btn_start = 1'b1;
    step(1);
    n_cmp++;
    if (state_o !== 3'd1) begin
      n_err++;
      $display("FAIL press_after_reset: state=%0d required 1", state_o);
    end
    btn_start = 1'b0;
    step(1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_l = 4'd0;
    exp_r = 4'd0;
    reset = 1'b0;
    btn_start = 1'b0;
    hit = 1'b0;
    l_win = 1'b0;
    r_win = 1'b0;
    idle_pix();

    test_reset();
    test_serve();
    test_point_once();
    test_hit();
    test_start_ignored();
    test_void();
    test_game_over();
    test_reset_mid_point();

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d expected points never seen, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
